mbox_word_rx: RTL and testbench
===============================

# mbox_word_rx

Receive end of the WOU mailbox byte stream. It drains the byte-wide mailbox FIFO and reassembles each group of 4 bytes, least-significant byte first, into one 32-bit word. Each word is presented on a valid/ready port to the consuming logic. A partial word left stranded by a stalled sender is discarded after a programmable idle timeout and reported with a sticky error flag.

## Interface
Parameters:
- WOU_DW, 8, mailbox byte width; must be 8.
- WB_DW, 32, assembled word width; must be 4*WOU_DW.
- TMO_W, 8, width of the partial-word idle timeout counter; timeout = 2^TMO_W-1 cycles.

Ports:
- clk_i  in  1  single clock for all logic.
- rst_n_i  in  1  reset: asynchronous and active-low.
- mbox_empty_i  in  1  mailbox FIFO empty flag.
- mbox_rd_o  out  1  mailbox FIFO read strobe, one byte per asserted cycle.
- mbox_di_i  in  WOU_DW  mailbox read data, valid the cycle after mbox_rd_o.
- word_o  out  WB_DW  assembled word, little-endian byte order.
- word_vld_o  out  1  word_o valid.
- word_rdy_i  in  1  consumer accepts word_o when word_vld_o & word_rdy_i.
- err_o  out  1  sticky: a partial word was discarded by timeout.
- err_clr_i  in  1  clears err_o.
- word_cnt_o  out  16  count of accepted words, wraps.

## Operation
- States: FILL (collecting bytes) and HOLD (word_vld_o=1, waiting on consumer).
- Bookkeeping:
  - iss_cnt (0..4) counts reads issued for the current word.
  - byte_cnt (0..4) counts bytes captured.
  - rd_d is mbox_rd_o delayed one cycle.
- mbox_rd_o = (state==FILL) & ~mbox_empty_i & (iss_cnt<4). It is combinational on mbox_empty_i, so back-to-back reads are allowed.
- Capture: when rd_d=1, mbox_di_i is written to word_o[8*byte_cnt +: 8] and byte_cnt increments. Byte 0 lands in [7:0]; byte 3 lands in [31:24].
- Capture of the 4th byte switches to HOLD and sets word_vld_o the next cycle. word_o is stable throughout HOLD.
- HOLD and handshake:
  - word_vld_o & word_rdy_i → back to FILL.
  - iss_cnt and byte_cnt clear to 0.
  - word_cnt_o increments.
  - word_vld_o drops the next cycle.
- Timeout:
  - In FILL with 1 ≤ byte_cnt ≤ 3 and no capture this cycle, tmo_cnt increments; any capture clears it.
  - When tmo_cnt reaches 2^TMO_W-1: iss_cnt, byte_cnt and tmo_cnt clear, word_o clears, and err_o sets.
  - tmo_cnt does not run when byte_cnt=0 or in HOLD.
- Timeout and capture in the same cycle: the capture wins and tmo_cnt clears.
- err_o: set by timeout, cleared by err_clr_i. If set and clear happen in the same cycle, set wins.
- Only full 4-byte words are ever emitted; the block never outputs a partial word.

## Timing
- Reset (rst_n_i low, asynchronous): state=FILL; mbox_rd_o=0 (no reads until rst_n_i is high); word_o=0, word_vld_o=0, err_o=0, word_cnt_o=0; all counters 0.
- Reset mid-word or mid-HOLD: the partial or held word is lost, with no error flag.
- Read latency: rd at cycle N → data captured at the N+1 edge.
- Minimum latency:
  - First rd (cycle 0) to word_vld_o=1 is 5 cycles: reads in cycles 0–3, last capture at the cycle-4 edge, vld visible in cycle 5.
  - Word throughput with word_rdy_i held high is one word per 6 cycles.
- mbox_empty_i rising while a read is in flight: the in-flight byte is still captured. No rd is issued that cycle.
- iss_cnt stops at 4, so the block never reads a 5th byte before the handshake.
- word_cnt_o wraps from 16'hFFFF to 0.

## Test plan
- Reset and single word:
  - Stimulus: FIFO holds 8'h11, 8'h22, 8'h33, 8'h44; word_rdy_i=1.
  - Required: word_o=32'h44332211; word_vld_o high for 1 cycle; word_cnt_o=1; exactly 4 rd pulses.
- Backpressure:
  - Stimulus: 8 bytes queued; word_rdy_i=0 for 20 cycles, then 1.
  - Required: mbox_rd_o stays low during HOLD after 4 reads; the first word is stable; then the second word is delivered; word_cnt_o=2.
- Gapped source:
  - Stimulus: mbox_empty_i toggles every cycle.
  - Required: bytes are captured only after rd; the word is assembled correctly with no duplicate or missing byte.
- Timeout (TMO_W=4):
  - Stimulus: feed 2 bytes, then hold the FIFO empty.
  - Required: after 15 idle cycles err_o=1, no word emitted; the next 4 bytes form a clean word.
  - Then pulse err_clr_i: err_o returns to 0.
- Async reset mid-word:
  - Stimulus: assert rst_n_i low between byte 2 and byte 3 capture.
  - Required: all outputs 0 immediately.
  - After release, the next 4 bytes form a fresh word.
- Counter wrap:
  - Stimulus: preload via 65536 accepted words, or force word_cnt_o to 16'hFFFF, then complete 1 word.
  - Required: word_cnt_o=0.

Source files
------------

// File: rtl/mbox_word_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mbox_word_rx
// Brief    : Drains the byte-wide mailbox FIFO and packs 4 bytes (LSB first)
//            into 32-bit words on a valid/ready port; stale partials time out.
// Revision : 1.0 - initial release
// ============================================================================
module mbox_word_rx #(
    parameter int WOU_DW = 8,
    parameter int WB_DW  = 32,
    parameter int TMO_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              mbox_empty_i,
    output logic              mbox_rd_o,
    input  logic [WOU_DW-1:0] mbox_di_i,
    output logic [WB_DW-1:0]  word_o,
    output logic              word_vld_o,
    input  logic              word_rdy_i,
    output logic              err_o,
    input  logic              err_clr_i,
    output logic [15:0]       word_cnt_o
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_e              state_q;
    logic                run_q;
    logic [2:0]          iss_cnt_q;
    logic [2:0]          byte_cnt_q;
    logic                rd_dly_q;
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic [WB_DW-1:0]    word_q;
    logic                word_vld_q;
    logic                err_q;
    logic [15:0]         word_cnt_q;

    logic                capture_d;
    logic                hshake_d;
    logic                idle_d;
    logic                tmo_fire_d;

    always_comb begin
        capture_d  = rd_dly_q;
        hshake_d   = word_vld_q & word_rdy_i;
        idle_d     = (state_q == FILL) & (byte_cnt_q != 3'd0) & ~capture_d;
        tmo_fire_d = idle_d & (tmo_cnt_q == TMO_LAST);
        // run_q keeps the read strobe low until the first edge after reset release
        mbox_rd_o  = run_q & (state_q == FILL) & ~mbox_empty_i & (iss_cnt_q < 3'd4);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= FILL;
            run_q      <= 1'b0;
            iss_cnt_q  <= 3'd0;
            byte_cnt_q <= 3'd0;
            rd_dly_q   <= 1'b0;
            tmo_cnt_q  <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
            err_q      <= 1'b0;
            word_cnt_q <= 16'd0;
        end else begin
            run_q    <= 1'b1;
            rd_dly_q <= mbox_rd_o;

            if (tmo_fire_d) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end

            if (hshake_d) begin
                state_q    <= FILL;
                word_vld_q <= 1'b0;
                iss_cnt_q  <= 3'd0;
                byte_cnt_q <= 3'd0;
                tmo_cnt_q  <= '0;
                word_cnt_q <= word_cnt_q + 16'd1;
            end else if (tmo_fire_d) begin
                // A read issued this very cycle becomes byte 0 of the next word
                iss_cnt_q  <= {2'b00, mbox_rd_o};
                byte_cnt_q <= 3'd0;
                tmo_cnt_q  <= '0;
                word_q     <= '0;
            end else begin
                if (mbox_rd_o) begin
                    iss_cnt_q <= iss_cnt_q + 3'd1;
                end
                if (capture_d) begin
                    word_q[byte_cnt_q[1:0]*WOU_DW +: WOU_DW] <= mbox_di_i;
                    byte_cnt_q <= byte_cnt_q + 3'd1;
                    tmo_cnt_q  <= '0;
                    if (byte_cnt_q == 3'd3) begin
                        state_q    <= HOLD;
                        word_vld_q <= 1'b1;
                    end
                end else if (idle_d) begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                end
            end
        end
    end

    assign word_o     = word_q;
    assign word_vld_o = word_vld_q;
    assign err_o      = err_q;
    assign word_cnt_o = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mbox_word_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mbox_word_rx
// Brief    : Scoreboard bench for mbox_word_rx with a byte FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbox_word_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mbox_empty = 1'b1;
    logic        mbox_rd;
    logic [7:0]  mbox_di = 8'h00;
    logic [31:0] word;
    logic        word_vld;
    logic        word_rdy;
    logic        err;
    logic        err_clr;
    logic [15:0] word_cnt;

    always #5 clk = ~clk;

    mbox_word_rx #(.WOU_DW(8), .WB_DW(32), .TMO_W(4)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .mbox_empty_i (mbox_empty),
        .mbox_rd_o    (mbox_rd),
        .mbox_di_i    (mbox_di),
        .word_o       (word),
        .word_vld_o   (word_vld),
        .word_rdy_i   (word_rdy),
        .err_o        (err),
        .err_clr_i    (err_clr),
        .word_cnt_o   (word_cnt)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  fifo[$];
    logic [31:0] sb[$];
    bit          gap_en = 1'b0;
    bit          gap_ph = 1'b0;
    int          rd_cnt = 0;
    int          vld_cyc = 0;
    int          n_got = 0;
    logic        vld_prev = 1'b0;
    logic [31:0] word_prev = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte FIFO model: one-cycle read latency, random data when not read
    always @(posedge clk) begin
        if (mbox_rd) begin
            chk("rd_nonempty", 32'(fifo.size() != 0), 32'd1);
            if (fifo.size() != 0) mbox_di <= fifo.pop_front();
        end else begin
            mbox_di <= 8'($urandom);
        end
        gap_ph     <= ~gap_ph;
        mbox_empty <= (fifo.size() <= (mbox_rd ? 1 : 0)) || (gap_en && !gap_ph);
    end

    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (rst_n) begin
            if (mbox_rd) rd_cnt++;
            if (word_vld) begin
                vld_cyc++;
                chk("rd_in_hold", 32'(mbox_rd), 32'd0);
                if (vld_prev) chk("hold_stable", word, word_prev);
                if (word_rdy) begin
                    chk("word_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        exp_w = sb.pop_front();
                        chk("word", word, exp_w);
                    end
                    n_got++;
                end
            end
            vld_prev  = word_vld;
            word_prev = word;
        end else begin
            vld_prev = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input bit expect_out);
        for (int i = 0; i < 4; i++) fifo.push_back(w[8*i +: 8]);
        if (expect_out) sb.push_back(w);
    endtask

    task automatic wait_got(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && n_got < target; i++) tick(1);
        chk(tag, 32'(n_got), 32'(target));
    endtask

    initial begin
        logic [31:0] w1, w2;
        rst_n   = 1'b0;
        word_rdy = 1'b0;
        err_clr = 1'b0;

        // Reset with data already waiting: no reads, all outputs zero
        push_word(32'h44332211, 1'b1);
        word_rdy = 1'b1;
        tick(3);
        chk("rst_rd",   32'(mbox_rd),  32'd0);
        chk("rst_word", word,          32'd0);
        chk("rst_vld",  32'(word_vld), 32'd0);
        chk("rst_err",  32'(err),      32'd0);
        chk("rst_cnt",  32'(word_cnt), 32'd0);
        rst_n = 1'b1;

        // Single word
        wait_got("t1_got", 1, 50);
        tick(3);
        chk("t1_rd_pulses", 32'(rd_cnt),  32'd4);
        chk("t1_vld_cycles", 32'(vld_cyc), 32'd1);
        chk("t1_cnt", 32'(word_cnt), 32'd1);

        // Backpressure
        word_rdy = 1'b0;
        w1 = $urandom;
        w2 = $urandom;
        push_word(w1, 1'b1);
        push_word(w2, 1'b1);
        tick(20);
        chk("t2_vld_held",  32'(word_vld), 32'd1);
        chk("t2_hold_word", word, w1);
        chk("t2_rd_pulses", 32'(rd_cnt), 32'd8);
        word_rdy = 1'b1;
        wait_got("t2_got", 3, 60);
        tick(2);
        chk("t2_cnt", 32'(word_cnt), 32'd3);
        chk("t2_rd_total", 32'(rd_cnt), 32'd12);

        // Gapped source
        gap_en = 1'b1;
        push_word($urandom, 1'b1);
        wait_got("t3_got", 4, 80);
        gap_en = 1'b0;
        tick(2);
        chk("t3_rd_total", 32'(rd_cnt), 32'd16);

        // Timeout on a 2-byte partial word
        fifo.push_back(8'hA5);
        fifo.push_back(8'h5A);
        tick(17);
        chk("t4_err_early", 32'(err), 32'd0);
        for (int i = 0; i < 20 && !err; i++) tick(1);
        chk("t4_err_set", 32'(err), 32'd1);
        chk("t4_word_clr", word, 32'd0);
        chk("t4_no_word", 32'(n_got), 32'd4);
        push_word($urandom, 1'b1);
        wait_got("t4_got", 5, 50);
        chk("t4_err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t4_err_clr", 32'(err), 32'd0);

        // Async reset between the 2nd and 3rd byte capture
        push_word(32'hCAFEF00D, 1'b0);
        tick(4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_word", word, 32'd0);
        chk("t5_vld",  32'(word_vld), 32'd0);
        chk("t5_err",  32'(err), 32'd0);
        chk("t5_cnt",  32'(word_cnt), 32'd0);
        chk("t5_rd",   32'(mbox_rd), 32'd0);
        fifo.delete();
        sb.delete();
        tick(2);
        rst_n = 1'b1;
        push_word($urandom, 1'b1);
        wait_got("t5_got", 6, 50);
        tick(1);
        chk("t5_cnt_after", 32'(word_cnt), 32'd1);

        // Counter wrap
        force dut.word_cnt_q = 16'hFFFF;
        tick(1);
        release dut.word_cnt_q;
        tick(1);
        chk("t6_preload", 32'(word_cnt), 32'h0000_FFFF);
        push_word($urandom, 1'b1);
        wait_got("t6_got", 7, 50);
        tick(1);
        chk("t6_wrap", 32'(word_cnt), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
